twmul_stage: RTL and testbench
==============================

// Module: twmul_stage
// PURPOSE
//  Twiddle-multiply stage of the 512-point pipelined FFT: 16 parallel lanes per beat, 32 beats (groups) per frame.
//  Generates grp_idx for the downstream-facing twiddle ROM block (twf0_1, registered, 1-cycle latency).
//  Aligns input data with the returned twiddles and computes lane-wise complex products.
//  Rounds, saturates and emits results to the next butterfly stage. Streaming only: no backpressure.
// PARAMETERS
//  DW     13  signed data width (re and im) at input and output
//  LANES  16  parallel lanes per beat (fixed by ROM block; from fft_pkg)
//  TW_W   10  twiddle width, signed Q2.8 (+1.0 = +256; from fft_pkg)
// PORTS
//  clk        in   1           rising-edge clock
//  rstn       in   1           async active-low reset
//  in_valid   in   1           input beat valid
//  in_sof     in   1           first beat of frame (qualified by in_valid)
//  din_re     in   DW x16      signed lane data, real
//  din_im     in   DW x16      signed lane data, imag
//  grp_idx    out  5           twiddle group request to ROM block (combinational)
//  tw_re      in   TW_W x16    ROM twiddle real, valid 1 cycle after grp_idx
//  tw_im      in   TW_W x16    ROM twiddle imag
//  dout_valid out  1           output beat valid
//  dout_sof   out  1           output first beat of frame
//  dout_re    out  DW x16      product real, rounded/saturated
//  dout_im    out  DW x16      product imag
//  sof_err    out  1           1-cycle pulse: in_sof accepted while group counter != 0
// BEHAVIOUR
//  Reset: grp_cnt=0, all valid/sof/pipeline regs=0, dout_re/dout_im=0, sof_err=0. Async assert, sync-released use.
//  Group counter (grp_cnt, 5b):
//   grp_idx = (in_valid && in_sof) ? 0 : grp_cnt.
//   On in_valid: grp_cnt <= grp_idx + 1, wrapping 31 -> 0 (mod 32).
//   No in_valid: grp_cnt holds; grp_idx still driven, but the ROM result is ignored.
//   in_valid && in_sof && grp_cnt != 0: restart at group 0 and pulse sof_err next cycle.
//  Pipeline (valid-tagged, no stalls, bubbles propagate):
//   S1 (t+1): register din, in_valid, in_sof; ROM twiddles for this beat arrive the same cycle.
//   S2 (t+2): register the 4 products per lane (ar*tr, ai*ti, ar*ti, ai*tr), each DW+TW_W bits signed.
//   S3 (t+3): re = ar*tr - ai*ti; im = ar*ti + ai*tr (DW+TW_W+1 bits).
//    Then add 128 and arithmetic-shift right by 8 (round half up).
//    Then saturate to [-2^(DW-1), 2^(DW-1)-1] and register to dout_*.
//  Latency: exactly 3 cycles from in_valid to dout_valid; dout_sof aligned with its beat.
//  Data regs load only when their stage valid=1; dout_re/dout_im hold their last value when dout_valid=0.
//  Reset mid-frame clears the pipeline (in-flight beats are lost) and restarts grp_cnt at 0.
//  Back-to-back frames: sof on the beat after group 31 is legal and raises no sof_err.
// STRUCTURE
//  fft_pkg: LANES=16, TW_W=10, TW_FRAC=8, GRP_W=5, NGRP=32, and typedef cplx_tw_t.
//  Sub-module twmul_cmul: one-lane 2-stage complex multiply with round/saturate.
//   16 instances via generate; the top holds the counter and the valid/sof pipeline.
//  twf0_1 is instantiated beside this block at the parent level, not inside it.
// TESTING
//  tw=256+0j, din=100-50j all lanes, single valid beat -> dout=100-50j at exactly t+3, dout_valid for 1 cycle.
//  tw=0-256j (-j), din=100+50j -> dout=50-100j.
//  DW=13, din=4095+4095j, tw=181+181j -> re=0, im saturates to 4095; din=-4096-4096j -> im=-4096.
//  Rounding, tw=128+0j: din=1 -> 1, din=-1 -> 0, din=3 -> 2 (half rounds up).
//  sof, then 33 consecutive valid beats -> grp_idx 0..31,0; sof mid-frame at grp 7 -> grp_idx=0, sof_err pulse.
//  Random valid gaps vs. golden model, bit-exact; rstn low mid-frame -> outputs 0 next edge, grp restarts at 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT constants and the complex twiddle type used by the twiddle-multiply stage.
package fft_pkg;
    localparam int LANES   = 16;
    localparam int TW_W    = 10;
    localparam int TW_FRAC = 8;
    localparam int GRP_W   = 5;
    localparam int NGRP    = 32;

    typedef struct packed {
        logic signed [TW_W-1:0] re;
        logic signed [TW_W-1:0] im;
    } cplx_tw_t;
endpackage

// File: rtl/twmul_cmul.sv
// One-lane complex multiply: registered partial products, then combine, round half up,
// saturate and register the result (holds when no valid beat reaches the output stage).
module twmul_cmul
    import fft_pkg::*;
#(
    parameter int DW = 13
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en_mul,
    input  logic                   en_out,
    input  logic signed [DW-1:0]   ar,
    input  logic signed [DW-1:0]   ai,
    input  logic signed [TW_W-1:0] tr,
    input  logic signed [TW_W-1:0] ti,
    output logic signed [DW-1:0]   yr,
    output logic signed [DW-1:0]   yi
);
    localparam int PW = DW + TW_W;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] RND  = SW'(2 ** (TW_FRAC - 1));
    localparam logic signed [SW-1:0] MAXV = SW'(2 ** (DW - 1) - 1);
    localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (DW - 1)));

    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [SW-1:0] sum_r, sum_i, rnd_r, rnd_i;
    logic signed [DW-1:0] sat_r, sat_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
        end else if (en_mul) begin
            p_rr <= PW'(ar) * PW'(tr);
            p_ii <= PW'(ai) * PW'(ti);
            p_ri <= PW'(ar) * PW'(ti);
            p_ir <= PW'(ai) * PW'(tr);
        end
    end

    // Twiddles are Q2.8, so dropping TW_FRAC bits returns to the input scale.
    always_comb begin
        sum_r = SW'(p_rr) - SW'(p_ii);
        sum_i = SW'(p_ri) + SW'(p_ir);
        rnd_r = (sum_r + RND) >>> TW_FRAC;
        rnd_i = (sum_i + RND) >>> TW_FRAC;
        sat_r = rnd_r[DW-1:0];
        sat_i = rnd_i[DW-1:0];
        if (rnd_r > MAXV) sat_r = MAXV[DW-1:0];
        else if (rnd_r < MINV) sat_r = MINV[DW-1:0];
        if (rnd_i > MAXV) sat_i = MAXV[DW-1:0];
        else if (rnd_i < MINV) sat_i = MINV[DW-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            yr <= '0;
            yi <= '0;
        end else if (en_out) begin
            yr <= sat_r;
            yi <= sat_i;
        end
    end
endmodule

// File: rtl/twmul_stage.sv
// Twiddle-multiply stage: drives the twiddle ROM group index, aligns data with the
// returned twiddles and emits rounded/saturated complex products 3 cycles later.
module twmul_stage
    import fft_pkg::*;
#(
    parameter int DW = 13
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic [LANES*DW-1:0]     din_re,
    input  logic [LANES*DW-1:0]     din_im,
    output logic [GRP_W-1:0]        grp_idx,
    input  logic [LANES*TW_W-1:0]   tw_re,
    input  logic [LANES*TW_W-1:0]   tw_im,
    output logic                    dout_valid,
    output logic                    dout_sof,
    output logic [LANES*DW-1:0]     dout_re,
    output logic [LANES*DW-1:0]     dout_im,
    output logic                    sof_err
);
    logic [GRP_W-1:0]    grp_cnt;
    logic                v1, s1, v2, s2;
    logic [LANES*DW-1:0] d1_re, d1_im;

    // A start-of-frame forces group 0 regardless of where the counter was.
    assign grp_idx = (in_valid && in_sof) ? '0 : grp_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grp_cnt <= '0;
            sof_err <= 1'b0;
        end else begin
            sof_err <= in_valid && in_sof && (grp_cnt != '0);
            if (in_valid) grp_cnt <= grp_idx + GRP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1         <= 1'b0;
            s1         <= 1'b0;
            v2         <= 1'b0;
            s2         <= 1'b0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
        end else begin
            v1         <= in_valid;
            s1         <= in_valid && in_sof;
            v2         <= v1;
            s2         <= v1 && s1;
            dout_valid <= v2;
            dout_sof   <= v2 && s2;
        end
    end

    // Data is held in S1 so it lines up with the ROM's 1-cycle twiddle latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d1_re <= '0;
            d1_im <= '0;
        end else if (in_valid) begin
            d1_re <= din_re;
            d1_im <= din_im;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        cplx_tw_t tw;
        assign tw.re = tw_re[l*TW_W +: TW_W];
        assign tw.im = tw_im[l*TW_W +: TW_W];

        twmul_cmul #(.DW(DW)) u_cmul (
            .clk    (clk),
            .rstn   (rstn),
            .en_mul (v1),
            .en_out (v2),
            .ar     (d1_re[l*DW +: DW]),
            .ai     (d1_im[l*DW +: DW]),
            .tr     (tw.re),
            .ti     (tw.im),
            .yr     (dout_re[l*DW +: DW]),
            .yi     (dout_im[l*DW +: DW])
        );
    end
endmodule

// File: tb/tb_twmul_stage.sv
// Self-checking bench for twmul_stage: ROM model, group-counter model and a scoreboard of
// golden complex products compared when the DUT raises dout_valid.
module tb_twmul_stage;
    import fft_pkg::*;

    localparam int DW = 13;
    localparam int VW = LANES * DW;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  in_valid, in_sof;
    logic [VW-1:0]         din_re, din_im;
    logic [GRP_W-1:0]      grp_idx;
    logic [LANES*TW_W-1:0] tw_re = '0, tw_im = '0;
    logic                  dout_valid, dout_sof, sof_err;
    logic [VW-1:0]         dout_re, dout_im;

    typedef struct {
        logic          sof;
        logic [VW-1:0] re;
        logic [VW-1:0] im;
        int            cyc;
    } beat_t;

    beat_t sb[$];
    int    twRe[NGRP][LANES];
    int    twIm[NGRP][LANES];
    int    testsRun = 0, testsFailed = 0;
    int    cyc = 0, modelCnt = 0;
    logic  errNext = 1'b0, errExpNow = 1'b0;

    twmul_stage #(.DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .din_re     (din_re),
        .din_im     (din_im),
        .grp_idx    (grp_idx),
        .tw_re      (tw_re),
        .tw_im      (tw_im),
        .dout_valid (dout_valid),
        .dout_sof   (dout_sof),
        .dout_re    (dout_re),
        .dout_im    (dout_im),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;

    // Registered twiddle ROM model: one cycle from grp_idx to tw_*.
    always @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            tw_re[l*TW_W +: TW_W] <= TW_W'(twRe[grp_idx][l]);
            tw_im[l*TW_W +: TW_W] <= TW_W'(twIm[grp_idx][l]);
        end
    end

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        errExpNow <= rstn ? errNext : 1'b0;
    end

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] satRound(input longint x);
        longint y;
        y = (x + 128) >>> 8;
        if (y > 4095) y = 4095;
        if (y < -4096) y = -4096;
        return y[DW-1:0];
    endfunction

    function automatic logic [VW-1:0] fill(input int v);
        logic [VW-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [VW-1:0] randLanes();
        logic [VW-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic setTwConst(input int tr, input int ti);
        for (int g = 0; g < NGRP; g++)
            for (int l = 0; l < LANES; l++) begin
                twRe[g][l] = tr;
                twIm[g][l] = ti;
            end
    endtask

    task automatic setTwRandom();
        for (int g = 0; g < NGRP; g++)
            for (int l = 0; l < LANES; l++) begin
                twRe[g][l] = int'($urandom_range(0, 1023)) - 512;
                twIm[g][l] = int'($urandom_range(0, 1023)) - 512;
            end
    endtask

    // One call per clock cycle; idle cycles are calls with v=0.
    task automatic applyStimulus(input logic v, input logic s, input logic [VW-1:0] re, input logic [VW-1:0] im);
        int     idx;
        beat_t  b;
        longint ar, ai, tr, ti;
        @(posedge clk);
        #1;
        in_valid = v;
        in_sof   = s;
        din_re   = re;
        din_im   = im;
        idx      = (v && s) ? 0 : modelCnt;
        errNext  = v && s && (modelCnt != 0);
        #1;
        checkOutput("grp_idx", grp_idx, idx);
        if (v) begin
            modelCnt = (idx + 1) % NGRP;
            b.sof = s;
            b.cyc = cyc + 3;
            for (int l = 0; l < LANES; l++) begin
                ar = longint'($signed(re[l*DW +: DW]));
                ai = longint'($signed(im[l*DW +: DW]));
                tr = longint'(twRe[idx][l]);
                ti = longint'(twIm[idx][l]);
                b.re[l*DW +: DW] = satRound(ar * tr - ai * ti);
                b.im[l*DW +: DW] = satRound(ar * ti + ai * tr);
            end
            sb.push_back(b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    // Output side of the scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t b;
        if (rstn) begin
            checkOutput("sof_err", sof_err, errExpNow);
            if (dout_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_valid", dout_valid, 1'b0);
                end else begin
                    b = sb.pop_front();
                    checkOutput("dout_re", dout_re, b.re);
                    checkOutput("dout_im", dout_im, b.im);
                    checkOutput("dout_sof", dout_sof, b.sof);
                    checkOutput("latency", cyc, b.cyc);
                end
            end
        end
    end

    initial begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
        din_re   = '0;
        din_im   = '0;
        setTwConst(0, 0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_dout_valid", dout_valid, 1'b0);
        checkOutput("rst_dout_sof", dout_sof, 1'b0);
        checkOutput("rst_dout_re", dout_re, '0);
        checkOutput("rst_dout_im", dout_im, '0);
        checkOutput("rst_sof_err", sof_err, 1'b0);
        checkOutput("rst_grp_idx", grp_idx, 0);
        @(negedge clk);
        rstn = 1'b1;

        setTwConst(256, 0);
        applyStimulus(1'b1, 1'b1, fill(100), fill(-50));
        idle(5);

        setTwConst(0, -256);
        applyStimulus(1'b1, 1'b1, fill(100), fill(50));
        idle(5);

        setTwConst(181, 181);
        applyStimulus(1'b1, 1'b1, fill(4095), fill(4095));
        applyStimulus(1'b1, 1'b0, fill(-4096), fill(-4096));
        idle(5);

        setTwConst(128, 0);
        applyStimulus(1'b1, 1'b1, fill(1), fill(-1));
        applyStimulus(1'b1, 1'b0, fill(3), fill(-3));
        idle(5);

        setTwRandom();
        applyStimulus(1'b1, 1'b1, randLanes(), randLanes());
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, randLanes(), randLanes());
        idle(4);

        applyStimulus(1'b1, 1'b1, randLanes(), randLanes());
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, randLanes(), randLanes());
        applyStimulus(1'b1, 1'b1, randLanes(), randLanes());
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, randLanes(), randLanes());
        idle(4);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 70)
                applyStimulus(1'b1, ($urandom_range(0, 99) < 5), randLanes(), randLanes());
            else
                applyStimulus(1'b0, 1'b0, randLanes(), randLanes());
        end
        idle(5);

        // Mid-frame reset: in-flight beats are dropped and the counter restarts.
        applyStimulus(1'b1, 1'b1, randLanes(), randLanes());
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, randLanes(), randLanes());
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rstn     = 1'b0;
        sb.delete();
        modelCnt = 0;
        errNext  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mrst_dout_valid", dout_valid, 1'b0);
        checkOutput("mrst_dout_re", dout_re, '0);
        checkOutput("mrst_dout_im", dout_im, '0);
        checkOutput("mrst_grp_idx", grp_idx, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, randLanes(), randLanes());
        idle(6);

        checkOutput("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
